vrased_log_drain: RTL and testbench

Read-out stage downstream of the VRASED violation logger. On request it walks the 37-bit log RAM from address 0 up to the logger's current write pointer and streams each entry to a consumer over a valid/ready handshake. It can optionally pulse `clr_ram` once the drain completes, so the logger restarts from an empty log. It drives the RAM read port (`re`, `rd_addr`, `rd_data`); the logger keeps the write port.

---
 rtl/vrased_log_drain.sv | 106 ++++++++++
 tb/tb_vrased_log_drain.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/vrased_log_drain.sv
// rtl/vrased_log_drain.sv - streams VRASED violation log RAM entries to a consumer
module vrased_log_drain #(
  parameter logic [15:0] DEPTH        = 16'd1024,
  parameter bit          CLR_ON_DRAIN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] wr_ptr,
  output logic        re,
  output logic [15:0] rd_addr,
  input  logic [36:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [36:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        clr_ram
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_PRESENT, S_CLEAR, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] idx, count;
  logic [15:0] start_count;
  logic        is_last;

  // Entries beyond the RAM depth cannot exist, so the walk saturates at DEPTH.
  assign start_count = (wr_ptr > DEPTH) ? DEPTH : wr_ptr;
  assign is_last     = (count != 16'd0) && (idx == count - 16'd1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx      <= 16'd0;
      count    <= 16'd0;
      out_data <= 37'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            count <= start_count;
            idx   <= 16'd0;
          end
        end
        S_WAIT:    out_data <= rd_data;
        S_PRESENT: if (out_ready && !is_last) idx <= idx + 16'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (start_count == 16'd0) ? S_DONE : S_READ;
      end
      S_READ: state_nxt = S_WAIT;
      S_WAIT: state_nxt = S_PRESENT;
      S_PRESENT: begin
        if (out_ready) begin
          if (is_last) state_nxt = CLR_ON_DRAIN ? S_CLEAR : S_DONE;
          else         state_nxt = S_READ;
        end
      end
      S_CLEAR: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    re        = 1'b0;
    rd_addr   = 16'd0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    clr_ram   = 1'b0;
    case (state)
      S_READ: begin
        re      = 1'b1;
        rd_addr = idx;
      end
      S_PRESENT: begin
        out_valid = 1'b1;
        out_last  = is_last;
      end
      S_CLEAR: clr_ram = 1'b1;
      S_DONE:  done    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vrased_log_drain.sv
// tb/tb_vrased_log_drain.sv - directed self-checking bench for vrased_log_drain
module tb_vrased_log_drain;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  start, out_ready;
  logic [15:0] wr_ptr [2];
  logic [1:0]  re, out_valid, out_last, busy, done, clr_ram;
  logic [15:0] rd_addr [2];
  logic [36:0] rd_data [2];
  logic [36:0] out_data [2];
  logic [36:0] mem0 [4];
  logic [36:0] mem1 [4];

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  // Instance 0: default depth, clears after drain. Instance 1: depth 4, never clears.
  vrased_log_drain u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .wr_ptr(wr_ptr[0]),
    .re(re[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_last(out_last[0]), .busy(busy[0]), .done(done[0]), .clr_ram(clr_ram[0])
  );

  vrased_log_drain #(.DEPTH(16'd4), .CLR_ON_DRAIN(1'b0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .wr_ptr(wr_ptr[1]),
    .re(re[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_last(out_last[1]), .busy(busy[1]), .done(done[1]), .clr_ram(clr_ram[1])
  );

  always @(posedge clk) begin
    if (re[0]) rd_data[0] <= mem0[rd_addr[0][1:0]];
    if (re[1]) rd_data[1] <= mem1[rd_addr[1][1:0]];
  end

  int          nxfer, nre, nvalid, clr_cnt, clr_cyc, done_cnt, done_cyc, busy_cnt;
  int          stall_bad, stall_re, zero_after_rst;
  int          xfer_cyc [8];
  logic [36:0] xfer_data [8];
  logic [15:0] re_addr [8];
  logic [7:0]  last_bits;
  logic [36:0] stall_d0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle c counts from the first cycle after the edge that samples start (c=1 is T+1).
  task automatic run(input int b, input logic [15:0] wp, input int ncyc,
                     input int st_from, input int st_len, input int restart_at, input int rst_at);
    nxfer = 0; nre = 0; nvalid = 0; clr_cnt = 0; clr_cyc = -1; done_cnt = 0; done_cyc = -1;
    busy_cnt = 0; stall_bad = 0; stall_re = 0; zero_after_rst = -1; last_bits = 8'd0;
    stall_d0 = 37'd0;
    for (int i = 0; i < 8; i++) begin
      xfer_cyc[i] = -1; xfer_data[i] = 37'd0; re_addr[i] = 16'hffff;
    end
    @(negedge clk);
    start[b] = 1'b1; wr_ptr[b] = wp; out_ready[b] = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start[b]     = (c == restart_at);
      out_ready[b] = !(c >= st_from && c < st_from + st_len);
      reset_n      = (c != rst_at);
      #1;
      if (c == rst_at + 1)
        zero_after_rst = ({re[b], rd_addr[b], out_valid[b], out_last[b], busy[b],
                           done[b], clr_ram[b], out_data[b]} == 59'd0) ? 1 : 0;
      if (out_valid[b]) nvalid++;
      if (out_valid[b] && out_ready[b]) begin
        if (nxfer < 8) begin
          xfer_cyc[nxfer]  = c;
          xfer_data[nxfer] = out_data[b];
          last_bits[nxfer] = out_last[b];
        end
        nxfer++;
      end
      if (re[b]) begin
        if (nre < 8) re_addr[nre] = rd_addr[b];
        nre++;
      end
      if (c >= st_from && c < st_from + st_len) begin
        if (c == st_from) stall_d0 = out_data[b];
        if (!out_valid[b] || out_data[b] !== stall_d0) stall_bad++;
        if (re[b]) stall_re++;
      end
      if (clr_ram[b]) begin clr_cnt++; clr_cyc = c; end
      if (done[b])    begin done_cnt++; done_cyc = c; end
      if (busy[b])    busy_cnt++;
    end
    start[b] = 1'b0; out_ready[b] = 1'b1; reset_n = 1'b1;
  endtask

  initial begin
    mem0[0] = 37'h1_0000_00A0; mem0[1] = 37'h1_0000_00B1;
    mem0[2] = 37'h1_0000_00C2; mem0[3] = 37'h1_0000_00D3;
    mem1[0] = 37'h0_1234_0D00; mem1[1] = 37'h0_1234_0D01;
    mem1[2] = 37'h0_1234_0D02; mem1[3] = 37'h1_FFFF_0D03;
    rd_data[0] = 37'd0; rd_data[1] = 37'd0;
    reset_n = 1'b0; start = 2'b00; out_ready = 2'b11;
    wr_ptr[0] = 16'd0; wr_ptr[1] = 16'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {re[0], rd_addr[0], out_valid[0], out_last[0], busy[0],
                          done[0], clr_ram[0], out_data[0]}, 64'd0);
    reset_n = 1'b1;

    // Basic drain of three entries.
    run(0, 16'd3, 16, 0, 0, 0, 0);
    chk("basic_nxfer", nxfer, 3);
    chk("basic_cyc0", xfer_cyc[0], 3);
    chk("basic_cyc1", xfer_cyc[1], 6);
    chk("basic_cyc2", xfer_cyc[2], 9);
    chk("basic_data0", xfer_data[0], 37'h1_0000_00A0);
    chk("basic_data1", xfer_data[1], 37'h1_0000_00B1);
    chk("basic_data2", xfer_data[2], 37'h1_0000_00C2);
    chk("basic_last", last_bits, 8'b0000_0100);
    chk("basic_clr", {clr_cnt, clr_cyc}, {32'd1, 32'd10});
    chk("basic_done", {done_cnt, done_cyc}, {32'd1, 32'd11});
    chk("basic_busy", busy_cnt, 11);

    // Five cycles of backpressure while entry 1 is presented.
    run(0, 16'd3, 20, 6, 5, 0, 0);
    chk("bp_nxfer", nxfer, 3);
    chk("bp_cyc1", xfer_cyc[1], 11);
    chk("bp_cyc2", xfer_cyc[2], 14);
    chk("bp_stall_data", stall_d0, 37'h1_0000_00B1);
    chk("bp_stall_stable", stall_bad, 0);
    chk("bp_stall_re", stall_re, 0);
    chk("bp_clr", clr_cyc, 15);
    chk("bp_done", done_cyc, 16);

    // Empty log.
    run(0, 16'd0, 6, 0, 0, 0, 0);
    chk("empty_done", {done_cnt, done_cyc}, {32'd1, 32'd1});
    chk("empty_re", nre, 0);
    chk("empty_valid", nvalid, 0);
    chk("empty_clr", clr_cnt, 0);
    chk("empty_busy", busy_cnt, 1);

    // Saturation at DEPTH=4, start re-pulsed during PRESENT, no clear.
    run(1, 16'h0009, 20, 0, 0, 3, 0);
    chk("sat_nxfer", nxfer, 4);
    chk("sat_nre", nre, 4);
    chk("sat_addr", {re_addr[0], re_addr[1], re_addr[2], re_addr[3]},
                    64'h0000_0001_0002_0003);
    chk("sat_last", last_bits, 8'b0000_1000);
    chk("sat_data3", xfer_data[3], 37'h1_FFFF_0D03);
    chk("noclr_clr", clr_cnt, 0);
    chk("noclr_done", {done_cnt, done_cyc}, {32'd1, 32'd13});
    chk("noclr_done_gap", done_cyc - xfer_cyc[3], 1);
    chk("sat_busy", busy_cnt, 13);

    // Reset during WAIT of entry 1 (cycle 5), then a fresh drain.
    run(0, 16'd3, 14, 0, 0, 0, 5);
    chk("rst_zero", zero_after_rst, 1);
    chk("rst_clr", clr_cnt, 0);
    chk("rst_done", done_cnt, 0);
    chk("rst_nxfer", nxfer, 1);
    run(0, 16'd3, 16, 0, 0, 0, 0);
    chk("rst_redrain_addr0", re_addr[0], 16'd0);
    chk("rst_redrain_nxfer", nxfer, 3);
    chk("rst_redrain_data0", xfer_data[0], 37'h1_0000_00A0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
